joypad_port: RTL
================

Name: joypad_port

Overview:
- CPU-bus responder for the two standard controller ports at $4016 (pad 0) and $4017 (pad 1).
- Emulates the console-facing behaviour of the pads' 4021 parallel-in/serial-out shift registers. Button states arrive as parallel vectors from the host/board.
- Sits beside the PPU and cartridge on the host bus. The top level decodes $4016/$4017 into I_host_wren and I_host_rden.
- The CPU strobes the latch by writing $4016 bit 0, then reads each port serially, one bit per read access.

Parameters:
P_bits, 8, shift register length per pad (buttons per pad)
P_open_bus, 8'h40, value driven on O_host_data bits 7:1 (bit 0 is replaced by the serial bit)

Ports:
I_clock  input  1  system clock
I_reset  input  1  synchronous, active-high reset
I_host_addr  input  1  CPU address bit 0: 0 = $4016 / pad 0, 1 = $4017 / pad 1
I_host_data  input  8  CPU write data
I_host_wren  input  1  write strobe, qualified by phy2 and the port select at the top level; may stay high for several clocks
I_host_rden  input  1  read strobe, qualified by phy2 and the port select at the top level; may stay high for several clocks
O_host_data  output  8  registered read data: {P_open_bus[7:1], serial bit of the selected pad}
I_pad0_buttons  input  P_bits  pad 0 state, 1 = pressed; bit0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right
I_pad1_buttons  input  P_bits  pad 1 state, same bit order
O_strobe  output  1  current latch/strobe level, for debug and external pads

Behaviour:
- One clock (I_clock). Reset is synchronous and active-high.
- Reset state:
  - strobe = 0
  - both shift registers all ones
  - r_rden_q = 0
  - O_host_data = {P_open_bus[7:1], 1'b1} (8'h41 at defaults)
  - O_strobe = 0
- Write:
  - Any clock with I_host_wren=1 and I_host_addr=0 sets strobe to I_host_data[0] on the next edge.
  - Writes with I_host_addr=1 are ignored ($4017 write belongs to the APU frame counter).
  - Holding wren for several clocks rewrites the same value; this is harmless.
- Reload: while strobe=1, each clock both shift registers load their I_padN_buttons vector. Reads then always return current A (bit0).
- Latch:
  - The falling edge of strobe freezes the registers with the values loaded on the last strobe=1 clock.
  - Clocks where the write sets strobe 1→0 still reload once, because reload uses the current strobe value.
- Shift:
  - Track r_rden_q, the registered I_host_rden.
  - A read access ends when r_rden_q=1 and I_host_rden=0.
  - At that edge the pad selected by the registered address of the access shifts right by one, filling the MSB with 1.
  - Exactly one shift per access, regardless of access length.
- Exhaustion: after P_bits shifts, reads return 1 indefinitely until the next reload.
- Simultaneous events:
  - strobe=1 and read-end on the same clock: reload wins, no shift.
  - Read of pad 1 never shifts pad 0, and vice versa.
- Read data:
  - O_host_data is registered each clock as {P_open_bus[7:1], shreg[I_host_addr][0]}. Latency is 1 clock from address, matching synchronous memories on the bus.
  - The value during a held read reflects the bit before that access's shift.
- Reset mid-access: reset dominates everything. A read whose rden falls in the cycle after reset deasserts does not shift, because r_rden_q was cleared.
- Button inputs are assumed synchronous to I_clock; synchronisers live upstream.

Decomposition:
- Package joypad_pkg holds:
  - button index constants (BTN_A=0 … BTN_RIGHT=7)
  - localparam C_JOY_ADDR_BASE = 16'h4016 for the top-level decoder
- One natural sub-module, pad_shifter (P_bits), instantiated twice. It has I_clock, I_reset, I_load, I_buttons, I_shift and O_bit, with load-over-shift priority.
- joypad_port holds strobe, the read-end edge detect, address capture and output muxing.

Test Plan:
- Reset, then read $4016 ×3 with no strobe → O_host_data = 8'h41 each time, no change.
- Pad0 = 8'b0000_1001 (A+Start). Write $4016←1, then $4016←0, then 10 reads of $4016 → bit0 sequence 1,0,0,1,0,0,0,0,1,1.
- Strobe held at 1, pad0 A toggling 1/0 between reads, 3 reads → bit0 follows live A each read, no shift.
- Pad1 = 8'h80 (Right), pad0 = 8'hFF. Strobe pulse, then 8 reads of $4017 and 1 read of $4016 → $4017 gives 0×7 then 1. $4016 gives 1 (A), and pad0 has shifted only once.
- Read access with rden held 5 clocks, then rden low → exactly one shift. The next read returns bit1.
- Write $4017←1 → strobe unchanged (O_strobe=0). Reset asserted mid-sequence after 3 reads → next read 8'h41, shift registers all ones.

Source files
------------

// File: rtl/joypad_pkg.sv
// joypad_pkg: shared constants for the controller-port block.
//   - Button bit positions within a pad's parallel button vector.
//   - Base address of the two ports, for the top-level bus decoder.
//   - Helper that builds the CPU read word from the open-bus pattern
//     and the serial bit.
package joypad_pkg;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam logic [15:0] C_JOY_ADDR_BASE = 16'h4016;

  // Only bit 0 of a port read is driven by the pad; the rest floats to
  // whatever the bus last held.
  function automatic logic [7:0] joy_read_word(input logic [7:0] open_bus,
                                               input logic       serial_bit);
    return {open_bus[7:1], serial_bit};
  endfunction

endpackage

// File: rtl/joypad_port_pad_shifter.sv
// pad_shifter: model of one pad's parallel-in / serial-out shift register.
// Ports:
//   I_clock    system clock
//   I_reset    synchronous active-high reset (register goes all ones)
//   I_load     parallel load of I_buttons (has priority over I_shift)
//   I_buttons  parallel button state, 1 = pressed
//   I_shift    shift right by one, MSB filled with 1
//   O_bit      current serial output (register bit 0)
module pad_shifter #(
  parameter int P_bits = 8
) (
  input  logic              I_clock,
  input  logic              I_reset,
  input  logic              I_load,
  input  logic [P_bits-1:0] I_buttons,
  input  logic              I_shift,
  output logic              O_bit
);

  logic [P_bits-1:0] shreg_p1;

  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      shreg_p1 <= '1;
    end else if (I_load) begin
      shreg_p1 <= I_buttons;
    end else if (I_shift) begin
      shreg_p1 <= {1'b1, shreg_p1[P_bits-1:1]};
    end
  end

  assign O_bit = shreg_p1[0];

endmodule

// File: rtl/joypad_port.sv
// joypad_port: CPU-bus responder for the controller ports $4016 / $4017.
// Ports:
//   I_clock         system clock
//   I_reset         synchronous active-high reset
//   I_host_addr     CPU address bit 0 (0 = $4016 / pad 0, 1 = $4017 / pad 1)
//   I_host_data     CPU write data (bit 0 drives the strobe)
//   I_host_wren     decoded write strobe, may stay high several clocks
//   I_host_rden     decoded read strobe, may stay high several clocks
//   O_host_data     registered read word {P_open_bus[7:1], serial bit}
//   I_pad0_buttons  pad 0 button vector, 1 = pressed
//   I_pad1_buttons  pad 1 button vector, 1 = pressed
//   O_strobe        current strobe level
module joypad_port #(
  parameter int          P_bits     = 8,
  parameter logic [7:0]  P_open_bus = 8'h40
) (
  input  logic              I_clock,
  input  logic              I_reset,
  input  logic              I_host_addr,
  input  logic [7:0]        I_host_data,
  input  logic              I_host_wren,
  input  logic              I_host_rden,
  output logic [7:0]        O_host_data,
  input  logic [P_bits-1:0] I_pad0_buttons,
  input  logic [P_bits-1:0] I_pad1_buttons,
  output logic              O_strobe
);

  import joypad_pkg::*;

  logic strobe_p1;
  logic r_rden_q;
  logic addr_p1;
  logic read_end;
  logic shift0;
  logic shift1;
  logic bit0;
  logic bit1;
  logic unused_host_data;

  assign unused_host_data = ^I_host_data[7:1];

  // The access address is held from the last rden-high clock so that the
  // shift at read-end hits the pad that was actually read.
  assign read_end = r_rden_q & ~I_host_rden;
  assign shift0   = read_end & ~addr_p1;
  assign shift1   = read_end &  addr_p1;

  // Stage p1: strobe, read-end detect, address capture, read data
  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      strobe_p1   <= 1'b0;
      r_rden_q    <= 1'b0;
      addr_p1     <= 1'b0;
      O_host_data <= joy_read_word(P_open_bus, 1'b1);
    end else begin
      if (I_host_wren && !I_host_addr) begin
        strobe_p1 <= I_host_data[0];
      end
      r_rden_q <= I_host_rden;
      if (I_host_rden) begin
        addr_p1 <= I_host_addr;
      end
      O_host_data <= joy_read_word(P_open_bus, I_host_addr ? bit1 : bit0);
    end
  end

  assign O_strobe = strobe_p1;

  // Load uses the registered strobe, so the clock that writes 1->0 still
  // reloads once; load beats a coincident shift inside pad_shifter.
  pad_shifter #(.P_bits(P_bits)) u_pad0 (
    .I_clock   (I_clock),
    .I_reset   (I_reset),
    .I_load    (strobe_p1),
    .I_buttons (I_pad0_buttons),
    .I_shift   (shift0),
    .O_bit     (bit0)
  );

  pad_shifter #(.P_bits(P_bits)) u_pad1 (
    .I_clock   (I_clock),
    .I_reset   (I_reset),
    .I_load    (strobe_p1),
    .I_buttons (I_pad1_buttons),
    .I_shift   (shift1),
    .O_bit     (bit1)
  );

endmodule
